taxi_display: RTL and testbench

TAXI_DISPLAY -- requirements
Module: taxi_display

---
 rtl/taxi_pkg.sv | 37 +++
 rtl/bin2bcd20.sv | 57 +++++
 rtl/taxi_display.sv | 162 ++++++++++++++++
 tb/tb_taxi_display.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/taxi_pkg.sv
// Shared types, limits and segment table for the taxi meter display.
package taxi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int unsigned BIN_W     = 20;
  localparam int unsigned BCD_W     = 24;
  localparam logic [19:0] SAT_LIMIT = 20'd999999;
  localparam logic [7:0]  BLANK     = 8'hFF;

  // Active-low segment pattern for one BCD digit, dp off.
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 8'hC0;
      4'd1:    digit_seg = 8'hF9;
      4'd2:    digit_seg = 8'hA4;
      4'd3:    digit_seg = 8'hB0;
      4'd4:    digit_seg = 8'h99;
      4'd5:    digit_seg = 8'h92;
      4'd6:    digit_seg = 8'h82;
      4'd7:    digit_seg = 8'hF8;
      4'd8:    digit_seg = 8'h80;
      4'd9:    digit_seg = 8'h90;
      default: digit_seg = BLANK;
    endcase
  endfunction

  // Clamp a raw 32-bit reading to the six-digit display range.
  function automatic logic [19:0] sat20(input logic [31:0] v);
    sat20 = (v > 32'(SAT_LIMIT)) ? SAT_LIMIT : v[19:0];
  endfunction

endpackage

// File: rtl/bin2bcd20.sv
// Serial 20-bit binary to 6-digit BCD converter, one bit per clock.
module bin2bcd20
  import taxi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int unsigned CNT_W = 5;

  logic [BIN_W-1:0] sh_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj_c;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Add 3 to every nibble that would overflow past 9 after the next shift.
  always_comb begin
    adj_c = bcd_q;
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD field per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh_q   <= bin;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {bcd_q, sh_q} <= {adj_c, sh_q} << 1;
        cnt_q         <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/taxi_display.sv
// Taxi meter 8-digit multiplexed display: periodic snapshot, BCD convert, scan out.
module taxi_display
  import taxi_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 200000,
  parameter int unsigned SCAN_CYCLES    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] distance,
  input  logic [31:0] money,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        upd
);

  localparam int unsigned REF_W  = $clog2(REFRESH_CYCLES);
  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);

  state_t             state_q, state_d;
  logic               start_c;
  logic               tick_c;
  logic               conv_done_c;
  logic [REF_W-1:0]   ref_cnt_q;
  logic [SCAN_W-1:0]  scan_cnt_q;
  logic [2:0]         idx_q;
  logic [BCD_W-1:0]   dist_bcd, money_bcd;
  logic               dist_done, money_done;
  logic [BCD_W-1:0]   dist_disp_q, money_disp_q;
  logic [3:0]         digit_c;
  logic               dp_c;
  logic               blank_c;
  logic [7:0]         seg_c;
  logic               unused_low_digits;

  assign tick_c      = (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));
  assign conv_done_c = dist_done & money_done;

  // Digits below display resolution are converted but never shown.
  assign unused_low_digits = ^{dist_disp_q[7:0], money_disp_q[7:0]};

  // Free-running refresh counter; its wrap is the snapshot tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ref_cnt_q <= '0;
    else if (tick_c) ref_cnt_q <= '0;
    else             ref_cnt_q <= ref_cnt_q + REF_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; ticks arriving outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_c) begin
          state_d = CONV;
          start_c = 1'b1;
        end
      end
      CONV:    if (conv_done_c) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  bin2bcd20 u_dist_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .bin   (sat20(distance)),
    .bcd   (dist_bcd),
    .done  (dist_done)
  );

  bin2bcd20 u_money_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .bin   (sat20(money)),
    .bcd   (money_bcd),
    .done  (money_done)
  );

  // Snapshot the converted values and flag the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_disp_q  <= '0;
      money_disp_q <= '0;
      upd          <= 1'b0;
    end else begin
      upd <= (state_q == UPDATE);
      if (state_q == UPDATE) begin
        dist_disp_q  <= dist_bcd;
        money_disp_q <= money_bcd;
      end
    end
  end

  // Scan timer: step the lit digit every SCAN_CYCLES clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q + 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  // Pick the digit for the current scan position, with dp and leading-zero blanking.
  always_comb begin
    digit_c = '0;
    dp_c    = 1'b0;
    blank_c = 1'b0;
    case (idx_q)
      3'd0: digit_c = money_disp_q[11:8];
      3'd1: digit_c = money_disp_q[15:12];
      3'd2: begin
        digit_c = money_disp_q[19:16];
        dp_c    = 1'b1;
      end
      3'd3: begin
        digit_c = money_disp_q[23:20];
        blank_c = (money_disp_q[23:20] == 4'd0);
      end
      3'd4: digit_c = dist_disp_q[11:8];
      3'd5: begin
        digit_c = dist_disp_q[15:12];
        dp_c    = 1'b1;
      end
      3'd6: begin
        digit_c = dist_disp_q[19:16];
        blank_c = (dist_disp_q[23:16] == 8'd0);
      end
      default: begin
        digit_c = dist_disp_q[23:20];
        blank_c = (dist_disp_q[23:20] == 4'd0);
      end
    endcase
    seg_c = blank_c ? BLANK : (digit_seg(digit_c) & {~dp_c, 7'h7F});
  end

  // Registered digit drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= BLANK;
      seg <= BLANK;
    end else begin
      an  <= ~(8'b1 << idx_q);
      seg <= seg_c;
    end
  end

endmodule

// File: tb/tb_taxi_display.sv
// Scoreboard bench for taxi_display: stimulus pushes expected digit images, monitor checks on upd.
module tb_taxi_display;

  localparam int REF  = 100;
  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] distance = '0;
  logic [31:0] money = '0;
  logic [7:0]  an, seg;
  logic        upd;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_cnt;
  logic [63:0] exp_q[$];

  taxi_display #(.REFRESH_CYCLES(REF), .SCAN_CYCLES(SCAN)) dut (
    .clk      (clk),
    .rst      (rst),
    .distance (distance),
    .money    (money),
    .an       (an),
    .seg      (seg),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; ticks fall on multiples of REF.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
  endtask

  task automatic wait_upd();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (upd !== 1'b1 && t < 400);
    if (upd !== 1'b1) begin
      n_chk++;
      $display("FAIL upd_timeout: got no upd expected upd within 400 cycles");
    end
  endtask

  task automatic apply(input logic [31:0] d, input logic [31:0] m);
    distance = d;
    money    = m;
  endtask

  // Expected images, {an7,an6,an5,an4,an3,an2,an1,an0}.
  localparam logic [63:0] V0 = 64'hFFFF40C0_FF40C0C0; // 0, 0
  localparam logic [63:0] V1 = 64'hFFF924B0_A4309992; // 12345, 234500
  localparam logic [63:0] V2 = 64'h90901090_90109090; // saturated both
  localparam logic [63:0] V3 = 64'hFFFF12C0_FF40C0C0; // 5000, 0
  localparam logic [63:0] V4 = 64'hFFFF78C0_FF40C0C0; // 7000, 0
  localparam logic [63:0] V5 = 64'hF9C040C0_FF40C090; // 100000, 999
  localparam logic [63:0] V6 = 64'h90901090_FF40F9C0; // 999999, 1000

  // Stimulus.
  initial begin
    apply(32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_an", 64'(an), 64'hFF);
    chk("reset_seg", 64'(seg), 64'hFF);
    chk("reset_upd", 64'(upd), 64'h0);
    exp_q.push_back(V0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_seg", 64'(seg), 64'hC0);
    chk("post_reset_an", 64'(an), 64'hFE);

    wait_upd();
    apply(32'd12345, 32'd234500);
    exp_q.push_back(V1);
    wait_upd();
    apply(32'd1000000, 32'hFFFF_FFFF);
    exp_q.push_back(V2);
    wait_upd();

    // Change distance two clocks into the conversion.
    apply(32'd5000, 32'd0);
    exp_q.push_back(V3);
    repeat (80) @(posedge clk);
    #1 distance = 32'd7000;
    exp_q.push_back(V4);
    wait_upd();
    wait_upd();

    apply(32'd100000, 32'd999);
    exp_q.push_back(V5);
    wait_upd();

    // Reset two clocks into the next conversion; it must be abandoned.
    apply(32'd999999, 32'd1000);
    repeat (80) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midconv_rst_an", 64'(an), 64'hFF);
    chk("midconv_rst_seg", 64'(seg), 64'hFF);
    chk("midconv_rst_upd", 64'(upd), 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(V6);
    @(negedge clk);
    chk("rerst_seg", 64'(seg), 64'hC0);
    chk("rerst_an", 64'(an), 64'hFE);
    wait_upd();

    repeat (50) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Monitor: on every upd pop the expected image and read back a full scan round.
  initial begin : monitor
    logic [63:0] exp_v;
    logic [7:0]  got [8];
    logic [7:0]  an_log [40];
    logic [7:0]  exp_an;
    int p, s;
    logic ok;
    forever begin
      @(negedge clk);
      if (upd === 1'b1) begin
        chk("upd_latency", 64'(edge_cnt % REF), 64'd22);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_upd: got upd expected none at edge %0d", edge_cnt);
          exp_v = '0;
        end else begin
          exp_v = exp_q.pop_front();
        end
        @(negedge clk);
        chk("upd_width", 64'(upd), 64'h0);
        for (int b = 0; b < 8; b++) got[b] = 8'h00;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          an_log[j] = an;
          for (int b = 0; b < 8; b++) if (an == ~(8'b1 << b)) got[b] = seg;
        end
        for (int b = 0; b < 8; b++)
          chk($sformatf("digit_an%0d", b), 64'(got[b]), 64'(exp_v[8*b +: 8]));
        p = 0;
        for (int j = 1; j < 8; j++) if (p == 0 && an_log[j] != an_log[j-1]) p = j;
        s = 0;
        for (int b = 0; b < 8; b++) if (an_log[p] == ~(8'b1 << b)) s = b;
        ok = 1'b1;
        for (int k = 0; k < 32; k++) begin
          exp_an = ~(8'b1 << ((s + k / SCAN) % 8));
          if (an_log[p + k] != exp_an) ok = 1'b0;
        end
        chk("scan_seq", 64'(ok), 64'h1);
      end
    end
  end

endmodule
